// File: rtl/stream_fifo_ctrl.sv
// stream_fifo_ctrl: power-of-two valid/ready FIFO with optional fall-through bypass,
// occupancy count, almost-full/empty flags and flush. Define STREAM_FIFO_PEAK_EN for peak_o.
module stream_fifo_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 8,
    parameter int FALL_THROUGH = 0,
    parameter int AF_THRESH    = DEPTH - 1,
    parameter int AE_THRESH    = 1
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      flush_i,
    input  logic [DATA_WIDTH-1:0]     elem_in_i,
    input  logic                      elem_in_valid_i,
    output logic                      elem_in_ready_o,
    output logic [DATA_WIDTH-1:0]     elem_out_o,
    output logic                      elem_out_valid_o,
    input  logic                      elem_out_ready_i,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      almost_full_o,
`ifdef STREAM_FIFO_PEAK_EN
    output logic [$clog2(DEPTH):0]    peak_o,
`endif
    output logic                      almost_empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] AF_LVL = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LVL = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          empty, full, blocked;
    logic          push, pop, bypass, wr_en, rd_en;

    // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        wr_idx  = wr_ptr_q[AW-1:0];
        rd_idx  = rd_ptr_q[AW-1:0];
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        blocked = srst_i || flush_i;

        // A pop on a full FIFO frees the slot for a write in the same cycle.
        elem_in_ready_o = !blocked && (!full || elem_out_ready_i);

        if ((FALL_THROUGH != 0) && empty) begin
            elem_out_valid_o = !blocked && elem_in_valid_i;
            elem_out_o       = elem_in_i;
        end else begin
            elem_out_valid_o = !blocked && !empty;
            elem_out_o       = mem_q[rd_idx];
        end

        push   = elem_in_valid_i && elem_in_ready_o;
        pop    = elem_out_valid_o && elem_out_ready_i;
        bypass = (FALL_THROUGH != 0) && empty && push && pop;
        wr_en  = push && !bypass;
        rd_en  = pop && !bypass;

        wr_ptr_d = wr_en ? wr_ptr_q + ONE : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + ONE : rd_ptr_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_idx] <= elem_in_i;
        end
    end

    assign count_o        = count_q;
    assign almost_full_o  = (count_q >= AF_LVL);
    assign almost_empty_o = (count_q <= AE_LVL);

`ifdef STREAM_FIFO_PEAK_EN
    logic [CW-1:0] peak_q, peak_d;

    // count never exceeds DEPTH, so the high-water mark saturates there on its own.
    always_comb begin
        peak_d = (count_d > peak_q) ? count_d : peak_q;
        if (flush_i) begin
            peak_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_o = peak_q;
`endif

endmodule

// File: tb/tb_stream_fifo_ctrl.sv
// Self-checking bench for stream_fifo_ctrl: one registered-output and one fall-through
// instance, each compared every cycle against a queue-based reference model.
module tb_stream_fifo_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int AF    = DEPTH - 1;
    localparam int AE    = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          srst[2], flush[2], in_valid[2], in_ready[2];
    logic          out_valid[2], out_ready[2], af[2], ae[2];
    logic [DW-1:0] in_data[2], out_data[2];
    logic [CW-1:0] count[2];
`ifdef STREAM_FIFO_PEAK_EN
    logic [CW-1:0] peak[2];
    int            peak_m[2];
`endif

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        stream_fifo_ctrl #(
            .DATA_WIDTH  (DW),
            .DEPTH       (DEPTH),
            .FALL_THROUGH(g),
            .AF_THRESH   (AF),
            .AE_THRESH   (AE)
        ) u_dut (
            .clk_i           (clk),
            .srst_i          (srst[g]),
            .flush_i         (flush[g]),
            .elem_in_i       (in_data[g]),
            .elem_in_valid_i (in_valid[g]),
            .elem_in_ready_o (in_ready[g]),
            .elem_out_o      (out_data[g]),
            .elem_out_valid_o(out_valid[g]),
            .elem_out_ready_i(out_ready[g]),
            .count_o         (count[g]),
            .almost_full_o   (af[g]),
`ifdef STREAM_FIFO_PEAK_EN
            .peak_o          (peak[g]),
`endif
            .almost_empty_o  (ae[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on instance s: drive inputs, check outputs against the model, advance it.
    task automatic step(input string tag, input int s, input logic rst, input logic fl,
                        input logic v, input logic [DW-1:0] d, input logic r);
        logic [DW-1:0] q[$];
        logic [DW-1:0] e_dat;
        logic          blk, e_ir, e_ov, push, pop, was_empty;
        if (s == 0) q = q0; else q = q1;

        @(negedge clk);
        srst[s] = rst; flush[s] = fl; in_valid[s] = v; in_data[s] = d; out_ready[s] = r;
        #1;
        blk   = rst || fl;
        e_ir  = !blk && (q.size() < DEPTH || r);
        e_ov  = !blk && (q.size() > 0 || (s == 1 && v));
        e_dat = (q.size() > 0) ? q[0] : d;

        check($sformatf("%s/count%0d", tag, s), 32'(count[s]), q.size());
        check($sformatf("%s/afull%0d", tag, s), 32'(af[s]), 32'(q.size() >= AF));
        check($sformatf("%s/aempty%0d", tag, s), 32'(ae[s]), 32'(q.size() <= AE));
        check($sformatf("%s/in_ready%0d", tag, s), 32'(in_ready[s]), 32'(e_ir));
        check($sformatf("%s/out_valid%0d", tag, s), 32'(out_valid[s]), 32'(e_ov));
        if (e_ov) check($sformatf("%s/data%0d", tag, s), 32'(out_data[s]), 32'(e_dat));
`ifdef STREAM_FIFO_PEAK_EN
        check($sformatf("%s/peak%0d", tag, s), 32'(peak[s]), peak_m[s]);
`endif

        push      = v && e_ir;
        pop       = e_ov && r;
        was_empty = (q.size() == 0);
        if (blk) begin
            q.delete();
        end else begin
            if (pop && !was_empty) e_dat = q.pop_front();
            if (push && !(pop && was_empty)) q.push_back(d);
        end
`ifdef STREAM_FIFO_PEAK_EN
        if (blk) peak_m[s] = 0;
        else if (q.size() > peak_m[s]) peak_m[s] = q.size();
`endif
        if (s == 0) q0 = q; else q1 = q;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            srst[i] = 1'b1; flush[i] = 1'b0; in_valid[i] = 1'b0;
            in_data[i] = '0; out_ready[i] = 1'b0;
`ifdef STREAM_FIFO_PEAK_EN
            peak_m[i] = 0;
`endif
        end
        repeat (2) @(posedge clk);

        // Fill to full with consumer stalled, then drain in order.
        for (int i = 0; i < DEPTH; i++) step("t1push", 0, 0, 0, 1, DW'(i), 0);
        step("t1full", 0, 0, 0, 1, 8'hFF, 0);
        for (int i = 0; i < DEPTH; i++) step("t1pop", 0, 0, 0, 0, 8'h00, 1);
        step("t1idle", 0, 0, 0, 0, 8'h00, 0);

        // Full FIFO streaming: simultaneous push and pop keep the count at DEPTH.
        for (int i = 0; i < DEPTH; i++) step("t2fill", 0, 0, 0, 1, DW'(8'h40 + i), 0);
        for (int i = 0; i < 4; i++) step("t2stream", 0, 0, 0, 1, DW'(8'h20 + i), 1);
        for (int i = 0; i < DEPTH; i++) step("t2drain", 0, 0, 0, 0, 8'h00, 1);

        // Fall-through bypass on an empty FIFO, then a plain write when the consumer stalls.
        step("t3bypass", 1, 0, 0, 1, 8'hA5, 1);
        step("t3after", 1, 0, 0, 0, 8'h00, 0);
        step("t3stall", 1, 0, 0, 1, 8'hA5, 0);
        step("t3held", 1, 0, 0, 0, 8'h00, 0);
        step("t3pop", 1, 0, 0, 0, 8'h00, 1);
        step("t3empty", 1, 0, 0, 0, 8'h00, 0);

        // Flush with a valid write in the flush cycle.
        for (int i = 0; i < 5; i++) step("t5fill", 0, 0, 0, 1, DW'(8'h50 + i), 0);
        step("t5flush", 0, 0, 1, 1, 8'h55, 0);
        step("t5after", 0, 0, 0, 0, 8'h00, 1);

        // Reset together with flush mid-operation, then a single clean transfer.
        for (int i = 0; i < 3; i++) step("t6fill", 0, 0, 0, 1, DW'(8'h60 + i), 0);
        step("t6reset", 0, 1, 1, 1, 8'h77, 1);
        step("t6after", 0, 0, 0, 1, 8'h11, 0);
        step("t6pop", 0, 0, 0, 0, 8'h00, 1);
        step("t6empty", 0, 0, 0, 0, 8'h00, 1);

        // Randomised interleaving on both instances; enough pushes to wrap the pointers often.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 120; i++) begin
                step("t4rand", s, 0, ($urandom_range(0, 59) == 0),
                     ($urandom_range(0, 9) < 8), DW'($urandom), ($urandom_range(0, 9) < 6));
            end
            for (int i = 0; i < DEPTH + 1; i++) step("t4drain", s, 0, 0, 0, 8'h00, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
